// File: rtl/riscv_mem_resp.sv
// Memory responder for the core's fetch and data ports: shared word RAM, MMIO (CYCLE/TOHOST/SCRATCH), RUN/HALT control.
// Optional feature macro: MEM_RESP_ALIGN_CHK_EN enables misalignment errors and the sticky err_o flag.
module riscv_mem_resp #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] iaddr_i,
  input  logic        ird_i,
  output logic [31:0] irdata_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic        drd_i,
  input  logic        dwr_i,
  output logic [31:0] drdata_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        halt_o,
  output logic [31:0] exit_code_o,
  output logic [31:0] cycle_cnt_o,
  output logic        err_o
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [0:0]    r_state;
  logic [31:0]   r_cycle;
  logic [31:0]   r_scratch;
  logic [31:0]   r_exit;

  logic          w_mmio;
  logic          w_run;
  logic          w_dmis;
  logic          w_imis;
  logic [AW-1:0] w_didx;
  logic [AW-1:0] w_iidx;
  logic [AW-1:0] w_lidx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_rd_shift;
  logic [31:0]   w_rd_ext;
  logic [31:0]   w_mmio_rdata;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic          w_unused;

  assign w_mmio     = (daddr_i[31:16] == MMIO_BASE[31:16]);
  assign w_run      = (r_state == ST_RUN);
  assign w_didx     = daddr_i[AW+1:2];
  assign w_iidx     = iaddr_i[AW+1:2];
  assign w_lidx     = load_addr_i[AW+1:2];
  assign w_rd_word  = r_mem[w_didx];
  assign w_rd_shift = w_rd_word >> {daddr_i[1:0], 3'b000};
  assign w_ram_we   = dwr_i & w_run & ~w_mmio & ~w_dmis;
  assign w_mmio_we  = dwr_i & w_run & w_mmio & (dsize_i == 2'b10) & ~w_dmis;
  assign w_unused   = ^{iaddr_i, load_addr_i};

`ifdef MEM_RESP_ALIGN_CHK_EN
  assign w_dmis = (drd_i | dwr_i) &
                  (((dsize_i == 2'b01) & daddr_i[0]) | (dsize_i[1] & (daddr_i[1:0] != 2'b00)));
  assign w_imis = ird_i & (iaddr_i[1:0] != 2'b00);
`else
  assign w_dmis = 1'b0;
  assign w_imis = 1'b0;
`endif

  // Write lane enables and lane-replicated write data
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = dwdata_i;
    case (dsize_i)
      2'b00: begin
        w_be    = 4'b0001 << daddr_i[1:0];
        w_wdata = {4{dwdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = daddr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{dwdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = dwdata_i;
      end
    endcase
  end

  // Right-aligned, zero-extended RAM read data
  always_comb begin
    w_rd_ext = w_rd_word;
    case (dsize_i)
      2'b00:   w_rd_ext = {24'h00_0000, w_rd_shift[7:0]};
      2'b01:   w_rd_ext = daddr_i[1] ? {16'h0000, w_rd_word[31:16]} : {16'h0000, w_rd_word[15:0]};
      default: w_rd_ext = w_rd_word;
    endcase
  end

  // MMIO read mux; size is ignored so narrow reads see the whole register
  always_comb begin
    w_mmio_rdata = 32'h0000_0000;
    case (daddr_i[15:2])
      14'd0:   w_mmio_rdata = r_cycle;
      14'd2:   w_mmio_rdata = r_scratch;
      default: w_mmio_rdata = 32'h0000_0000;
    endcase
  end

  // RAM writes; preload is issued last so it wins on a same-word collision
  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_didx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
    if (load_en_i) r_mem[w_lidx] <= load_data_i;
  end

  // Data read port; r_mem is sampled before this edge's write lands
  always_ff @(posedge clk_i) begin
    if (reset_i)     drdata_o <= 32'h0000_0000;
    else if (drd_i) begin
      if (w_dmis)      drdata_o <= ERR_WORD;
      else if (w_mmio) drdata_o <= w_mmio_rdata;
      else             drdata_o <= w_rd_ext;
    end
  end

  // Instruction read port
  always_ff @(posedge clk_i) begin
    if (reset_i)    irdata_o <= NOP_WORD;
    else if (ird_i) begin
      if (!w_run)      irdata_o <= NOP_WORD;
      else if (w_imis) irdata_o <= ERR_WORD;
      else             irdata_o <= r_mem[w_iidx];
    end
  end

  // RUN/HALT control, cycle counter and MMIO registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_RUN;
      r_cycle   <= 32'h0000_0000;
      r_scratch <= 32'h0000_0000;
      r_exit    <= 32'h0000_0000;
    end else if (w_run) begin
      r_cycle <= r_cycle + 32'h0000_0001;
      if (w_mmio_we && (daddr_i[15:2] == 14'd2)) r_scratch <= dwdata_i;
      if (w_mmio_we && (daddr_i[15:2] == 14'd1)) begin
        r_exit  <= dwdata_i;
        r_state <= ST_HALT;
      end
    end
  end

`ifdef MEM_RESP_ALIGN_CHK_EN
  logic r_err;
  // Sticky misalignment flag
  always_ff @(posedge clk_i) begin
    if (reset_i)              r_err <= 1'b0;
    else if (w_dmis | w_imis) r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign halt_o      = (r_state == ST_HALT);
  assign exit_code_o = r_exit;
  assign cycle_cnt_o = r_cycle;
endmodule

// File: doc/riscv_mem_resp.md
# riscv_mem_resp

Memory responder for the core's instruction-fetch and data ports: the target side of the `iaddr/irdata/ird` and `daddr/dwdata/drdata/dsize/drd/dwr` buses driven by `riscv_core_sim`. It provides a shared word RAM with byte and half-word write lanes and one-cycle registered reads. A small MMIO window holds a cycle counter, a scratch register and a TOHOST halt register. The bench-facing run/halt state machine lets simulations end when the core writes TOHOST.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; power of two.
- `MMIO_BASE`, 32'h0001_0000: base of the MMIO window; only bits [31:16] are decoded.
- `clk_i` in 1: clock. All state updates on the rising edge.
- `reset_i` in 1: reset. Synchronous, active-high.
- `iaddr_i` in 32: instruction byte address.
- `ird_i` in 1: instruction read request.
- `irdata_o` out 32: instruction word.
- `daddr_i` in 32: data byte address.
- `dwdata_i` in 32: write data, right-aligned.
- `dsize_i` in 2: access size; 2'b00 byte, 2'b01 half, 2'b10 word.
- `drd_i` in 1: data read request.
- `dwr_i` in 1: data write request.
- `drdata_o` out 32: data read result, right-aligned and zero-extended.
- `load_en_i` in 1: bench preload write enable.
- `load_addr_i` in 32: preload byte address; word-aligned.
- `load_data_i` in 32: preload word.
- `halt_o` out 1: TOHOST has been written.
- `exit_code_o` out 32: value written to TOHOST.
- `cycle_cnt_o` out 32: cycle counter value.
- `err_o` out 1: sticky access-error flag.

## Operation
- **Decode:** `daddr_i[31:16]==MMIO_BASE[31:16]` selects MMIO; everything else selects RAM. RAM word index is `addr[log2(DEPTH_WORDS)+1:2]`, so out-of-range addresses wrap. The instruction port always selects RAM.
- **RAM write lanes:**
  - byte: lane `addr[1:0]` gets `dwdata_i[7:0]`.
  - half: lanes {2·addr[1]+1, 2·addr[1]} get `dwdata_i[15:0]`.
  - word: all four lanes.
- **RAM read extraction:** byte = `word>>(8·addr[1:0])` masked to 8 bits; half = selected half masked to 16 bits; word = the full word. Sign extension is the core's job.
- **Simultaneous `drd_i` and `dwr_i`:** the write is performed, and `drdata_o` returns the pre-write data. An instruction fetch of a word written in the same cycle also returns the old word.
- **Preload:** `load_en_i` writes a full word in any state. On the same word in the same cycle, preload wins over `dwr_i`.
- **MMIO registers** (offsets from `MMIO_BASE`):
  - 0x0 CYCLE: read-only.
  - 0x4 TOHOST: write-only; reads return 0.
  - 0x8 SCRATCH: read/write, reset 0.
  - Other offsets read 0 and ignore writes.
  - Non-word MMIO writes are ignored. Non-word MMIO reads return the word.
- **State machine RUN → HALT:**
  - RUN: the counter increments every cycle and wraps 32'hFFFF_FFFF→0. A TOHOST write latches `dwdata_i` into `exit_code_o` and moves to HALT.
  - HALT: terminal until reset. The counter freezes. Core data writes (RAM and MMIO) are ignored. `irdata_o` returns 32'h0000_0013 (NOP). Data reads still work.
- **Reset mid-operation:** returns to RUN and clears the counter, SCRATCH, `halt_o`, `exit_code_o` and `err_o`. RAM contents are preserved.

## Timing
- **Reset values:** `irdata_o`=32'h0000_0013, `drdata_o`=0, `halt_o`=0, `exit_code_o`=0, `cycle_cnt_o`=0, `err_o`=0.
- **Read latency:** one cycle. Request at edge N gives data valid after edge N+1. With no request, the output register holds its value.
- **Halt timing:** `halt_o` rises on the edge that samples the TOHOST write. A write to the same word in that cycle is performed; later writes are dropped.
- **Counter:** `cycle_cnt_o` is 0 in the first cycle after reset release. A CYCLE read sampled at edge N returns the count before that edge's increment.

## Configuration
- **`MEM_RESP_ALIGN_CHK_EN` defined:**
  - Misaligned data accesses (half with addr[0]=1; word with addr[1:0]≠0) and fetches with `iaddr_i[1:0]≠0` are errors.
  - An erroring access drops the write, returns 32'hDEAD_BEEF on the read port and sets `err_o` on the same edge.
  - `err_o` is sticky until reset.
- **Undefined:** low address bits are ignored per the lane rules above, and `err_o` is tied 0.

## Test plan
- Preload 0x100←32'h1122_3344, then byte reads at 0x101 and 0x103 → `drdata_o`=0x33, then 0x11, each one cycle after request.
- Half write 0xBEEF to 0x102, then word read of 0x100 → 32'hBEEF_3344. Byte write 0x5A to 0x100 → 32'hBEEF_335A.
- Same-cycle `drd_i`/`dwr_i` word to 0x200 (old 0, new 0xCAFE_F00D) → read returns 0; next read returns 0xCAFE_F00D.
- Write 0x7 to TOHOST → `halt_o`=1 and `exit_code_o`=7 the next cycle. Then:
  - CYCLE frozen;
  - write to 0x300 ignored;
  - fetches return 0x13;
  - reset → all outputs at reset values.
- With `MEM_RESP_ALIGN_CHK_EN`, word write to 0x402 → RAM unchanged and `err_o`=1 sticky. Without the macro → the word at 0x400 is written and `err_o`=0.
